// File: rtl/dsp_test_pkg.sv
//============================================================================
// Module : dsp_test_pkg
// Brief  : Shared states, verdict codes and sizing helpers for the checker.
// Rev    : 1.0
//============================================================================
`default_nettype none

package dsp_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_PASS   = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  localparam logic [1:0] C_VERDICT_NONE = 2'b00;
  localparam logic [1:0] C_VERDICT_PASS = 2'b01;
  localparam logic [1:0] C_VERDICT_FAIL = 2'b10;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((longint'(1) << result) < longint'(value)) result = result + 1;
    return result;
  endfunction

  // Select width for an index into n items; never narrower than one bit.
  function automatic int bits_for_index(input int n);
    return (clog2(n) > 0) ? clog2(n) : 1;
  endfunction

  // Width of a counter that must be able to hold the value n itself.
  function automatic int bits_for_count(input int n);
    return (clog2(n + 1) > 0) ? clog2(n + 1) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//============================================================================
// Module : sat_counter
// Brief  : Saturating up-counter with clear and a look-ahead target match.
// Rev    : 1.0
//============================================================================
`default_nettype none

module sat_counter #(
  parameter int WIDTH  = 16,
  parameter int TARGET = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic             o_hit
);

  localparam logic [WIDTH-1:0] C_TARGET    = WIDTH'(TARGET);
  localparam bit               C_REACHABLE = ((longint'(TARGET) >> WIDTH) == 0);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_inc && !(&count_q)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  // Matches the value the counter will hold after this edge.
  assign o_hit   = C_REACHABLE && (count_d == C_TARGET);

endmodule

`default_nettype wire

// File: rtl/test_result_checker.sv
//============================================================================
// Module : test_result_checker
// Brief  : Counts compares per run, captures first mismatch, issues verdict.
// Rev    : 1.0
//============================================================================
`default_nettype none

module test_result_checker
  import dsp_test_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_CHANNELS   = 4,
  parameter int NUM_TESTS      = 16,
  parameter int SETTLE_CYCLES  = 200,
  parameter int TIMEOUT_CYCLES = 50000000,
  parameter int STOP_ON_FAIL   = 0,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                   wb_clk,
  input  logic                                   wb_rst,
  input  logic                                   start,
  input  logic                                   cmp_valid,
  input  logic [bits_for_index(NUM_CHANNELS)-1:0] cmp_chan,
  input  logic [DATA_WIDTH-1:0]                  cmp_expected,
  input  logic [DATA_WIDTH-1:0]                  cmp_measured,
  input  logic                                   all_done,
  output logic                                   busy,
  output logic                                   pass,
  output logic                                   fail,
  output logic                                   timeout,
  output logic [CNT_WIDTH-1:0]                   test_count,
  output logic [CNT_WIDTH-1:0]                   fail_count,
  output logic [NUM_CHANNELS-1:0]                chan_fail,
  output logic [CNT_WIDTH-1:0]                   first_fail_index,
  output logic [DATA_WIDTH-1:0]                  first_fail_expected,
  output logic [DATA_WIDTH-1:0]                  first_fail_measured
);

  localparam int                C_CHAN_W   = bits_for_index(NUM_CHANNELS);
  localparam int                C_SETTLE_W = bits_for_count(SETTLE_CYCLES);
  localparam int                C_TMO_W    = bits_for_count(TIMEOUT_CYCLES);
  localparam logic [C_CHAN_W:0] C_NUM_CH   = (C_CHAN_W + 1)'(NUM_CHANNELS);
  localparam bit                C_STOP     = (STOP_ON_FAIL != 0);
  localparam bit                C_NO_SETTLE = (SETTLE_CYCLES == 0);

  state_e                  state_q, state_d;
  logic                    timeout_q, timeout_d;
  logic [NUM_CHANNELS-1:0] chan_fail_q, chan_fail_d;
  logic [CNT_WIDTH-1:0]    ff_index_q, ff_index_d;
  logic [DATA_WIDTH-1:0]   ff_exp_q, ff_exp_d;
  logic [DATA_WIDTH-1:0]   ff_meas_q, ff_meas_d;

  logic                    w_active;
  logic                    w_accept;
  logic                    w_chan_ok;
  logic                    w_mismatch;
  logic                    w_test_hit;
  logic                    w_no_fail;
  logic                    w_settle_hit;
  logic                    w_settle_done;
  logic                    w_tmo_hit;
  logic [1:0]              w_verdict;
  logic [C_SETTLE_W-1:0]   w_settle_cnt;
  logic [C_TMO_W-1:0]      w_tmo_cnt;
  logic                    w_unused_cnt;

  assign w_active   = (state_q == ST_RUN) || (state_q == ST_SETTLE);
  assign w_accept   = cmp_valid && w_active && !start;
  assign w_chan_ok  = ({1'b0, cmp_chan} < C_NUM_CH);
  assign w_mismatch = w_accept && ((cmp_expected != cmp_measured) || !w_chan_ok);

  sat_counter #(.WIDTH(CNT_WIDTH), .TARGET(NUM_TESTS)) u_test_cnt (
    .clk(wb_clk), .rst(wb_rst), .i_clr(start), .i_inc(w_accept),
    .o_count(test_count), .o_hit(w_test_hit)
  );

  sat_counter #(.WIDTH(CNT_WIDTH), .TARGET(0)) u_fail_cnt (
    .clk(wb_clk), .rst(wb_rst), .i_clr(start), .i_inc(w_mismatch),
    .o_count(fail_count), .o_hit(w_no_fail)
  );

  sat_counter #(.WIDTH(C_SETTLE_W), .TARGET(SETTLE_CYCLES)) u_settle_cnt (
    .clk(wb_clk), .rst(wb_rst), .i_clr(start || (state_q != ST_SETTLE)),
    .i_inc(state_q == ST_SETTLE), .o_count(w_settle_cnt), .o_hit(w_settle_hit)
  );

  sat_counter #(.WIDTH(C_TMO_W), .TARGET(TIMEOUT_CYCLES)) u_tmo_cnt (
    .clk(wb_clk), .rst(wb_rst), .i_clr(start), .i_inc(w_active),
    .o_count(w_tmo_cnt), .o_hit(w_tmo_hit)
  );

  assign w_unused_cnt  = ^{w_settle_cnt, w_tmo_cnt};
  assign w_settle_done = w_settle_hit || C_NO_SETTLE;
  // Counter look-ahead folds in a compare arriving on the last settle cycle.
  assign w_verdict     = (w_no_fail && w_test_hit) ? C_VERDICT_PASS : C_VERDICT_FAIL;

  always_comb begin
    state_d     = state_q;
    timeout_d   = timeout_q;
    chan_fail_d = chan_fail_q;
    ff_index_d  = ff_index_q;
    ff_exp_d    = ff_exp_q;
    ff_meas_d   = ff_meas_q;

    if (start) begin
      state_d     = ST_RUN;
      timeout_d   = 1'b0;
      chan_fail_d = '0;
      ff_index_d  = '0;
      ff_exp_d    = '0;
      ff_meas_d   = '0;
    end else begin
      case (state_q)
        ST_RUN, ST_SETTLE: begin
          if (w_tmo_hit) begin
            state_d   = ST_FAIL;
            timeout_d = 1'b1;
          end else if (C_STOP && w_mismatch) begin
            state_d = ST_FAIL;
          end else if (state_q == ST_RUN) begin
            if (all_done) state_d = ST_SETTLE;
          end else if (w_settle_done) begin
            state_d = (w_verdict == C_VERDICT_PASS) ? ST_PASS : ST_FAIL;
          end
        end
        default: state_d = state_q;
      endcase

      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (w_mismatch && (32'(cmp_chan) == i)) chan_fail_d[i] = 1'b1;
      end

      if (w_mismatch && (fail_count == '0)) begin
        ff_index_d = test_count;
        ff_exp_d   = cmp_expected;
        ff_meas_d  = cmp_measured;
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q     <= ST_IDLE;
      timeout_q   <= 1'b0;
      chan_fail_q <= '0;
      ff_index_q  <= '0;
      ff_exp_q    <= '0;
      ff_meas_q   <= '0;
    end else begin
      state_q     <= state_d;
      timeout_q   <= timeout_d;
      chan_fail_q <= chan_fail_d;
      ff_index_q  <= ff_index_d;
      ff_exp_q    <= ff_exp_d;
      ff_meas_q   <= ff_meas_d;
    end
  end

  assign busy                = w_active;
  assign pass                = (state_q == ST_PASS);
  assign fail                = (state_q == ST_FAIL);
  assign timeout             = timeout_q;
  assign chan_fail           = chan_fail_q;
  assign first_fail_index    = ff_index_q;
  assign first_fail_expected = ff_exp_q;
  assign first_fail_measured = ff_meas_q;

endmodule

`default_nettype wire

// File: tb/tb_test_result_checker.sv
//============================================================================
// Module : tb_test_result_checker
// Brief  : Directed vector bench for test_result_checker (three configs).
// Rev    : 1.0
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_test_result_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, cmp_valid, all_done;
  logic [1:0]  cmp_chan;
  logic [31:0] cmp_exp, cmp_meas;

  // a_: default behaviour, s_: stop on first mismatch, t_: 4-bit counters, 3 channels
  logic        a_busy, a_pass, a_fail, a_tmo;
  logic [15:0] a_tc, a_fc, a_ffi;
  logic [3:0]  a_cf;
  logic [31:0] a_ffe, a_ffm;
  logic        s_busy, s_pass, s_fail, s_tmo;
  logic [15:0] s_tc, s_fc, s_ffi;
  logic [3:0]  s_cf;
  logic [31:0] s_ffe, s_ffm;
  logic        t_busy, t_pass, t_fail, t_tmo;
  logic [3:0]  t_tc, t_fc, t_ffi;
  logic [2:0]  t_cf;
  logic [31:0] t_ffe, t_ffm;

  test_result_checker #(.TIMEOUT_CYCLES(1000), .STOP_ON_FAIL(0)) dut (
    .wb_clk(clk), .wb_rst(rst), .start(start), .cmp_valid(cmp_valid), .cmp_chan(cmp_chan),
    .cmp_expected(cmp_exp), .cmp_measured(cmp_meas), .all_done(all_done),
    .busy(a_busy), .pass(a_pass), .fail(a_fail), .timeout(a_tmo), .test_count(a_tc),
    .fail_count(a_fc), .chan_fail(a_cf), .first_fail_index(a_ffi),
    .first_fail_expected(a_ffe), .first_fail_measured(a_ffm)
  );

  test_result_checker #(.TIMEOUT_CYCLES(1000), .STOP_ON_FAIL(1)) dut_sof (
    .wb_clk(clk), .wb_rst(rst), .start(start), .cmp_valid(cmp_valid), .cmp_chan(cmp_chan),
    .cmp_expected(cmp_exp), .cmp_measured(cmp_meas), .all_done(all_done),
    .busy(s_busy), .pass(s_pass), .fail(s_fail), .timeout(s_tmo), .test_count(s_tc),
    .fail_count(s_fc), .chan_fail(s_cf), .first_fail_index(s_ffi),
    .first_fail_expected(s_ffe), .first_fail_measured(s_ffm)
  );

  test_result_checker #(.TIMEOUT_CYCLES(1000), .NUM_CHANNELS(3), .CNT_WIDTH(4)) dut_sat (
    .wb_clk(clk), .wb_rst(rst), .start(start), .cmp_valid(cmp_valid), .cmp_chan(cmp_chan),
    .cmp_expected(cmp_exp), .cmp_measured(cmp_meas), .all_done(all_done),
    .busy(t_busy), .pass(t_pass), .fail(t_fail), .timeout(t_tmo), .test_count(t_tc),
    .fail_count(t_fc), .chan_fail(t_cf), .first_fail_index(t_ffi),
    .first_fail_expected(t_ffe), .first_fail_measured(t_ffm)
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        valid;
    logic [1:0]  chan;
    logic [31:0] e;
    logic [31:0] m;
    logic [15:0] tc;
    logic [15:0] fc;
    logic [3:0]  cf;
  } vec_t;

  vec_t vecs [18];

  function automatic vec_t mk(input logic v, input logic [1:0] c, input logic [31:0] e,
                              input logic [31:0] m, input logic [15:0] tc,
                              input logic [15:0] fc, input logic [3:0] cf);
    vec_t r;
    r.valid = v; r.chan = c; r.e = e; r.m = m; r.tc = tc; r.fc = fc; r.cf = cf;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_cmp(input logic [1:0] c, input logic [31:0] e, input logic [31:0] m);
    cmp_valid = 1'b1; cmp_chan = c; cmp_exp = e; cmp_meas = m;
    tick();
    cmp_valid = 1'b0;
  endtask

  task automatic do_done();
    all_done = 1'b1;
    tick();
    all_done = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cmp_valid = 1'b0; all_done = 1'b0;
    cmp_chan = '0; cmp_exp = '0; cmp_meas = '0;

    vecs[0]  = mk(1, 2'd0, 32'h00000000, 32'h00000000, 16'd1,  16'd0, 4'b0000);
    vecs[1]  = mk(1, 2'd1, 32'h11111111, 32'h11111111, 16'd2,  16'd0, 4'b0000);
    vecs[2]  = mk(1, 2'd2, 32'h22222222, 32'h22222222, 16'd3,  16'd0, 4'b0000);
    vecs[3]  = mk(1, 2'd3, 32'h33333333, 32'h33333333, 16'd4,  16'd0, 4'b0000);
    vecs[4]  = mk(1, 2'd0, 32'h44444444, 32'h44444444, 16'd5,  16'd0, 4'b0000);
    vecs[5]  = mk(1, 2'd2, 32'hDEADBEEF, 32'hDEADBEEE, 16'd6,  16'd1, 4'b0100);
    vecs[6]  = mk(1, 2'd3, 32'h66666666, 32'h66666666, 16'd7,  16'd1, 4'b0100);
    vecs[7]  = mk(1, 2'd0, 32'h77777777, 32'h77777777, 16'd8,  16'd1, 4'b0100);
    vecs[8]  = mk(0, 2'd1, 32'h00000001, 32'h00000002, 16'd8,  16'd1, 4'b0100);
    vecs[9]  = mk(1, 2'd1, 32'h88888888, 32'h88888888, 16'd9,  16'd1, 4'b0100);
    vecs[10] = mk(1, 2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 16'd10, 16'd1, 4'b0100);
    vecs[11] = mk(1, 2'd3, 32'hAAAAAAAA, 32'hAAAAAAAA, 16'd11, 16'd1, 4'b0100);
    vecs[12] = mk(1, 2'd0, 32'hBBBBBBBB, 32'hBBBBBBBB, 16'd12, 16'd1, 4'b0100);
    vecs[13] = mk(1, 2'd1, 32'hCCCCCCCC, 32'hCCCCCCCC, 16'd13, 16'd1, 4'b0100);
    vecs[14] = mk(1, 2'd2, 32'hDDDDDDDD, 32'hDDDDDDDD, 16'd14, 16'd1, 4'b0100);
    vecs[15] = mk(1, 2'd3, 32'hEEEEEEEE, 32'hEEEEEEEE, 16'd15, 16'd1, 4'b0100);
    vecs[16] = mk(0, 2'd3, 32'h0000FFFF, 32'hFFFF0000, 16'd15, 16'd1, 4'b0100);
    vecs[17] = mk(1, 2'd0, 32'h12345678, 32'h12345678, 16'd16, 16'd1, 4'b0100);

    tick(); tick();
    rst = 1'b0;
    check("rst.busy", a_busy, 0);
    check("rst.pass", a_pass, 0);
    check("rst.fail", a_fail, 0);
    check("rst.test_count", a_tc, 0);
    check("rst.chan_fail", a_cf, 0);

    // Clean run: 16 matches then verdict 200 cycles after SETTLE entry
    do_start();
    check("A.busy_after_start", a_busy, 1);
    for (int i = 0; i < 16; i++) do_cmp(2'(i % 4), 32'h1000 + 32'(i), 32'h1000 + 32'(i));
    do_done();
    check("A.busy_in_settle", a_busy, 1);
    repeat (199) tick();
    check("A.pass_before_199", a_pass, 0);
    tick();
    check("A.pass", a_pass, 1);
    check("A.fail", a_fail, 0);
    check("A.test_count", a_tc, 16);
    check("A.fail_count", a_fc, 0);

    // Table run: single mismatch at compare #5 on channel 2
    do_start();
    check("B.cleared_pass", a_pass, 0);
    for (int i = 0; i < 18; i++) begin
      cmp_valid = vecs[i].valid; cmp_chan = vecs[i].chan;
      cmp_exp = vecs[i].e; cmp_meas = vecs[i].m;
      tick();
      check($sformatf("B.v%0d.test_count", i), a_tc, vecs[i].tc);
      check($sformatf("B.v%0d.fail_count", i), a_fc, vecs[i].fc);
      check($sformatf("B.v%0d.chan_fail", i), a_cf, vecs[i].cf);
    end
    cmp_valid = 1'b0;
    do_done();
    repeat (200) tick();
    check("B.fail", a_fail, 1);
    check("B.pass", a_pass, 0);
    check("B.first_fail_index", a_ffi, 5);
    check("B.first_fail_expected", a_ffe, 32'hDEADBEEF);
    check("B.first_fail_measured", a_ffm, 32'hDEADBEEE);

    // Stop-on-fail: mismatch at compare #3
    do_start();
    for (int i = 0; i < 3; i++) do_cmp(2'(i), 32'h500 + 32'(i), 32'h500 + 32'(i));
    do_cmp(2'd1, 32'hCAFE0003, 32'hCAFE0013);
    check("C.sof_fail", s_fail, 1);
    check("C.sof_busy", s_busy, 0);
    check("C.sof_test_count", s_tc, 4);
    check("C.sof_first_index", s_ffi, 3);
    check("C.nostop_busy", a_busy, 1);
    do_cmp(2'd0, 32'h00000055, 32'h000000AA);
    check("C.sof_test_count_held", s_tc, 4);
    check("C.sof_fail_count_held", s_fc, 1);
    check("C.sof_first_exp", s_ffe, 32'hCAFE0003);
    check("C.test_count", a_tc, 5);
    check("C.fail_count", a_fc, 2);
    check("C.first_index_kept", a_ffi, 3);
    check("C.first_exp_kept", a_ffe, 32'hCAFE0003);
    check("C.first_meas_kept", a_ffm, 32'hCAFE0013);
    check("C.chan_fail", a_cf, 4'b0011);

    // Short run: 15 matches, last one together with all_done
    do_start();
    for (int i = 0; i < 14; i++) do_cmp(2'(i % 4), 32'h77, 32'h77);
    all_done = 1'b1;
    do_cmp(2'd2, 32'h77, 32'h77);
    all_done = 1'b0;
    check("D.busy_settle", a_busy, 1);
    repeat (200) tick();
    check("D.fail", a_fail, 1);
    check("D.pass", a_pass, 0);
    check("D.timeout", a_tmo, 0);
    check("D.test_count", a_tc, 15);

    // Timeout after 1000 cycles in RUN, then restart
    do_start();
    repeat (999) tick();
    check("E.fail_at_999", a_fail, 0);
    check("E.busy_at_999", a_busy, 1);
    tick();
    check("E.fail", a_fail, 1);
    check("E.timeout", a_tmo, 1);
    check("E.pass", a_pass, 0);
    do_start();
    check("E.restart_busy", a_busy, 1);
    check("E.restart_fail", a_fail, 0);
    check("E.restart_timeout", a_tmo, 0);

    // Reset during SETTLE
    do_cmp(2'd1, 32'h1, 32'h2);
    do_done();
    repeat (5) tick();
    check("F.busy_settle", a_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("F.busy", a_busy, 0);
    check("F.pass", a_pass, 0);
    check("F.fail", a_fail, 0);
    check("F.timeout", a_tmo, 0);
    check("F.test_count", a_tc, 0);
    check("F.fail_count", a_fc, 0);
    check("F.chan_fail", a_cf, 0);
    check("F.first_index", a_ffi, 0);
    check("F.first_exp", a_ffe, 0);
    check("F.first_meas", a_ffm, 0);
    do_done();
    check("F.done_ignored_busy", a_busy, 0);
    check("F.done_ignored_fail", a_fail, 0);
    do_cmp(2'd0, 32'h3, 32'h4);
    check("F.idle_cmp_ignored", a_tc, 0);
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("F.rst_over_start", a_busy, 0);

    // Saturation and out-of-range channel on the narrow instance
    do_start();
    for (int i = 0; i < 3; i++) do_cmp(2'd3, 32'h1, 32'h0);
    for (int i = 0; i < 17; i++) do_cmp(2'd0, 32'h2, 32'h3);
    check("G.sat_test_count", t_tc, 4'hF);
    check("G.sat_fail_count", t_fc, 4'hF);
    check("G.sat_chan_fail", t_cf, 3'b001);
    check("G.sat_first_index", t_ffi, 0);
    check("G.sat_first_exp", t_ffe, 32'h1);
    check("G.sat_first_meas", t_ffm, 32'h0);
    check("G.test_count", a_tc, 20);
    check("G.fail_count", a_fc, 20);
    check("G.chan_fail", a_cf, 4'b1001);
    check("G.never_both", {s_pass, s_fail}, 2'b01);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
